// File: rtl/velocity_cell_reader_pkg.sv
// Shared widths, state encoding and count-field location for the velocity cell reader.
package velocity_cell_reader_pkg;

  localparam int unsigned VEL_DATA_WIDTH = 96;
  localparam int unsigned VEL_ADDR_WIDTH = 8;

  // The particle count occupies the low bits of RAM word 0.
  localparam int unsigned CNT_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StCntReq,
    StCntWait,
    StStream,
    StDrain,
    StDone
  } vel_state_e;

endpackage

// File: rtl/velocity_stream_fifo.sv
// Small synchronous FIFO carrying {last, pid, data} from RAM return to the stream port.
module velocity_stream_fifo #(
  parameter int unsigned WIDTH     = 105,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned OCC_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 empty,
  output logic [OCC_WIDTH-1:0] occupancy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_WIDTH-1:0] occ_q;
  logic                 do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_push   = push && (occ_q < OCC_WIDTH'(DEPTH));
  assign do_pop    = pop && (occ_q != '0);
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  assign pop_data  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      occ_q <= occ_q + OCC_WIDTH'(do_push) - OCC_WIDTH'(do_pop);
    end
  end

endmodule

// File: rtl/velocity_cell_reader.sv
// Streams particles 1..N of one velocity cell RAM, credit-limited so the output FIFO never
// overflows while RAM latency is hidden.
module velocity_cell_reader
  import velocity_cell_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = VEL_DATA_WIDTH,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned ADDR_WIDTH   = VEL_ADDR_WIDTH,
  parameter int unsigned RAM_LATENCY  = 2,
  parameter int unsigned FIFO_DEPTH   = RAM_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int unsigned FifoW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned InW   = $clog2(RAM_LATENCY + 1);

  vel_state_e state_q, state_d;

  logic [InW-1:0]         wait_q;
  logic [ADDR_WIDTH-1:0]  count_q, rd_addr_q;
  logic [ADDR_WIDTH-1:0]  raw_count, clamped;
  logic [RAM_LATENCY-1:0] pipe_vld_q, pipe_last_q;
  logic [ADDR_WIDTH-1:0]  pipe_pid_q [RAM_LATENCY];
  logic [InW-1:0]         inflight;
  logic [OccW-1:0]        occupancy;
  logic                   fifo_empty, pop, issue, credit_ok, cnt_ready;
  logic [FifoW-1:0]       fifo_wr, fifo_rd;

  assign raw_count = ram_q[CNT_LSB +: ADDR_WIDTH];
  assign clamped   = (32'(raw_count) > PARTICLE_NUM - 1) ? ADDR_WIDTH'(PARTICLE_NUM - 1) : raw_count;
  assign cnt_ready = (state_q == StCntWait) && (wait_q == InW'(RAM_LATENCY - 1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RAM_LATENCY); i++) inflight = inflight + InW'(pipe_vld_q[i]);
  end

  assign credit_ok      = (32'(inflight) + 32'(occupancy)) < FIFO_DEPTH;
  assign out_valid      = !fifo_empty;
  assign pop            = out_valid && out_ready;
  assign ram_wren       = 1'b0;
  assign particle_count = count_q;

  always_comb begin
    state_d     = state_q;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    ram_rden    = 1'b0;
    ram_address = rd_addr_q;
    issue       = 1'b0;
    unique case (state_q)
      StIdle:    if (start) state_d = StCntReq;
      StCntReq: begin
        ram_rden    = 1'b1;
        ram_address = '0;
        state_d     = StCntWait;
      end
      // An empty cell still passes through DRAIN, fixing its done time at start+RAM_LATENCY+3.
      StCntWait: if (cnt_ready) state_d = (clamped == '0) ? StDrain : StStream;
      StStream: begin
        issue    = credit_ok;
        ram_rden = credit_ok;
        if (credit_ok && (rd_addr_q == count_q)) state_d = StDrain;
      end
      StDrain:   if ((count_q == '0) || (pop && out_last)) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_q == StCntWait) ? wait_q + 1'b1 : '0;
      if (cnt_ready) begin
        count_q   <= clamped;
        rd_addr_q <= ADDR_WIDTH'(1);
      end else if (issue) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end
    end
  end

  // Tag pipeline aligned with RAM latency; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < int'(RAM_LATENCY); i++) pipe_pid_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= (rd_addr_q == count_q);
      pipe_pid_q[0]  <= rd_addr_q;
      for (int i = 1; i < int'(RAM_LATENCY); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
        pipe_pid_q[i]  <= pipe_pid_q[i-1];
      end
    end
  end

  assign fifo_wr = {pipe_last_q[RAM_LATENCY-1], pipe_pid_q[RAM_LATENCY-1], ram_q};
  assign {out_last, out_pid, out_data} = fifo_rd;

  velocity_stream_fifo #(
    .WIDTH    (FifoW),
    .DEPTH    (FIFO_DEPTH),
    .OCC_WIDTH(OccW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pipe_vld_q[RAM_LATENCY-1]),
    .push_data(fifo_wr),
    .pop      (pop),
    .pop_data (fifo_rd),
    .empty    (fifo_empty),
    .occupancy(occupancy)
  );

endmodule
